// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES-128 inverse key schedule.
package aes_pkg;
    localparam int NR = 10;
    localparam int NK = 4;
    typedef logic [0:127] rk_t;
    typedef enum logic [1:0] {IDLE, FWD, OUT} state_e;
    // Indexed by round number; entries outside 1..10 are zero.
    localparam logic [15:0][7:0] RCON = {40'h0, 8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                         8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational FIPS-197 forward S-box.
module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign o_out = SBOX[{i_in, 3'b000} +: 8];
endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: expands an AES-128 key forward to K10, then streams
// round keys 10..0 by running the schedule backwards under a valid/ready handshake.
module aes_inv_key_sched
    import aes_pkg::state_e, aes_pkg::rk_t, aes_pkg::RCON,
           aes_pkg::IDLE, aes_pkg::FWD, aes_pkg::OUT;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [0:127] rk,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);
    localparam logic [3:0] LAST = 4'(NR);

    state_e      r_state, w_state;
    logic [3:0]  r_rc, w_rc, w_ridx;
    rk_t         r_w, w_w;
    logic        r_done;
    logic [0:31] w_w0, w_w1, w_w2, w_w3, w_sin, w_rot, w_sub, w_t, w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = r_w;
    // One shared S-box row: w3 going forward, p3 = w3^w2 going backward.
    assign w_sin  = (r_state == OUT) ? (w_w3 ^ w_w2) : w_w3;
    assign w_rot  = {w_sin[8:31], w_sin[0:7]};
    assign w_ridx = (r_state == OUT) ? r_rc : r_rc + 4'd1;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (.i_in(w_rot[8*g +: 8]), .o_out(w_sub[8*g +: 8]));
        end
    endgenerate

    assign w_t  = w_sub ^ {RCON[w_ridx], 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    always_comb begin
        w_state = r_state;
        w_rc    = r_rc;
        w_w     = r_w;
        case (r_state)
            IDLE: if (start) begin
                w_state = FWD;
                w_rc    = '0;
                w_w     = key;
            end
            FWD: begin
                w_w     = {w_n0, w_n1, w_n2, w_n3};
                w_rc    = r_rc + 4'd1;
                w_state = (w_rc == LAST) ? OUT : FWD;
            end
            OUT: if (rk_ready) begin
                if (r_rc == '0) begin
                    w_state = IDLE;
                end else begin
                    w_w  = {w_n0, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};
                    w_rc = r_rc - 4'd1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rc    <= '0;
            r_w     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_rc    <= w_rc;
            r_w     <= w_w;
            r_done  <= (r_state == OUT) && rk_ready && (r_rc == '0);
        end
    end

    assign rk_valid = (r_state == OUT);
    assign rk       = r_w;
    assign rk_idx   = r_rc;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: directed table-driven checks of the inverse key schedule.
module tb_aes_inv_key_sched;
    typedef logic [127:0] blk_t;
    typedef struct {
        blk_t key;
        blk_t ks [11];
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         rk_ready = 1'b1;
    logic [0:127] key = '0;
    logic         rk_valid, busy, done;
    logic [0:127] rk;
    logic [3:0]   rk_idx;
    int           n_chk = 0;
    int           n_err = 0;
    vec_t         tab [2];

    aes_inv_key_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .rk_ready(rk_ready),
        .rk_valid(rk_valid), .rk(rk), .rk_idx(rk_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input blk_t act, input blk_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full schedule from table entry v; optional stall, ignored start, or reset abort at a given index.
    task automatic sched(input int v, input int stall_at, input int poke_at, input int abort_at);
        key = tab[v].key;
        start = 1'b1;
        tick;
        start = 1'b0;
        key = ~tab[v].key;
        repeat (9) tick;
        chk("fwd_busy", busy, 1);
        chk("fwd_valid_early", rk_valid, 0);
        tick;
        for (int i = 10; i >= 0; i--) begin
            chk("valid", rk_valid, 1);
            chk("idx", rk_idx, i);
            chk("rk", rk, tab[v].ks[i]);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", rk_valid, 0);
                chk("rst_rk", rk, 0);
                chk("rst_idx", rk_idx, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                return;
            end
            if (i == stall_at) begin
                rk_ready = 1'b0;
                repeat (5) begin
                    tick;
                    chk("stall_valid", rk_valid, 1);
                    chk("stall_idx", rk_idx, i);
                    chk("stall_rk", rk, tab[v].ks[i]);
                end
                rk_ready = 1'b1;
            end
            start = (i == poke_at);
            tick;
            start = 1'b0;
        end
        chk("done", done, 1);
        chk("end_valid", rk_valid, 0);
        chk("end_busy", busy, 0);
        tick;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs, dn;
        logic seen;
        tab[0].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tab[0].ks  = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                       128'ha0fafe1788542cb123a339392a6c7605,
                       128'hf2c295f27a96b9435935807a7359f67f,
                       128'h3d80477d4716fe3e1e237e446d7a883b,
                       128'hef44a541a8525b7fb671253bdb0bad00,
                       128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                       128'h6d88a37a110b3efddbf98641ca0093fd,
                       128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                       128'head27321b58dbad2312bf5607f8d292f,
                       128'hac7766f319fadc2128d12941575c006e,
                       128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tab[1].key = '0;
        tab[1].ks  = '{128'h00000000000000000000000000000000,
                       128'h62636363626363636263636362636363,
                       128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
                       128'h90973450696ccffaf2f457330b0fac99,
                       128'hee06da7b876a1581759e42b27e91ee2b,
                       128'h7f2e2b88f8443e098dda7cbbf34b9290,
                       128'hec614b851425758c99ff09376ab49ba7,
                       128'h217517873550620bacaf6b3cc61bf09b,
                       128'h0ef903333ba9613897060a04511dfa9f,
                       128'hb1d4d8e28a7db9da1d7bb3de4c664941,
                       128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        #2 rst_n = 1'b0;
        #1;
        chk("init_valid", rk_valid, 0);
        chk("init_rk", rk, 0);
        chk("init_idx", rk_idx, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        for (int v = 0; v < 2; v++) sched(v, -1, -1, -1);
        sched(0, 7, -1, -1);
        sched(1, -1, 4, -1);

        sched(0, -1, -1, 5);
        tick;
        tick;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick;
            seen |= rk_valid | busy;
        end
        chk("abort_quiet", seen, 0);
        sched(0, -1, -1, -1);

        key = tab[0].key;
        start = 1'b1;
        tick;
        hs = 0;
        dn = 0;
        for (int c = 0; c < 66; c++) begin
            if (rk_valid && rk_ready) begin
                chk("b2b_idx", rk_idx, 10 - hs % 11);
                chk("b2b_rk", rk, tab[0].ks[10 - hs % 11]);
                hs++;
            end
            if (done) dn++;
            if (c == 65) start = 1'b0;
            tick;
        end
        chk("b2b_handshakes", hs, 33);
        chk("b2b_dones", dn, 3);
        chk("b2b_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 The block SHALL have parameter NR, default 10, meaning the number of AES-128 rounds; only 10 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new schedule; sampled only in IDLE.
REQ-005 The block SHALL have port key, input, [0:127]: AES-128 cipher key; word 0 is bits 0:31 and byte 0 is bits 0:7.
REQ-006 The block SHALL have port rk_ready, input, 1 bit: consumer accepts rk this cycle.
REQ-007 The block SHALL have port rk_valid, output, 1 bit: rk/rk_idx hold a valid round key.
REQ-008 The block SHALL have port rk, output, [0:127]: round key, same word/byte layout as key.
REQ-009 The block SHALL have port rk_idx, output, [3:0]: round number of rk, 0..10.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after round key 0 is accepted.

Function
REQ-012 The block SHALL have three FSM states: IDLE, FWD and OUT.
REQ-013 In IDLE with start=1, the block SHALL capture key into the working register, load round counter rc=0, and enter FWD.
REQ-014 In FWD, each cycle the block SHALL compute K(rc+1) from K(rc) per FIPS-197 (RotWord, SubWord, Rcon(rc+1)), replace the working register with it, and increment rc.
- When rc reaches 10, the block SHALL enter OUT.
- FWD SHALL last exactly 10 cycles.
REQ-015 If start is sampled at edge T, rk_valid SHALL first be high in cycle T+11, with rk=K10 and rk_idx=10.
REQ-016 In OUT, rk SHALL equal the working register and rk_idx SHALL equal rc.
REQ-017 On each cycle of OUT with rk_valid and rk_ready both high, and rc>0, the block SHALL compute K(rc-1) and decrement rc. For Kr = (w0,w1,w2,w3):
- p3 = w3^w2
- p2 = w2^w1
- p1 = w1^w0
- p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(rc)
REQ-018 When rk_ready is low in OUT, rk, rk_idx and rk_valid=1 SHALL hold stable.
REQ-019 A handshake at rc=0 SHALL deassert rk_valid, pulse done for exactly the next cycle, and return the FSM to IDLE.
REQ-020 Round keys SHALL be emitted strictly in order 10,9,...,0; exactly 11 handshakes SHALL occur per start.
REQ-021 start SHALL be ignored while busy=1; key SHALL be sampled only at an accepted start.
REQ-022 done and a new start MAY coincide: a start seen in the IDLE cycle where done=1 SHALL be accepted.
REQ-023 Rcon(i) for i=1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 in byte 0 of the word, with bytes 1..3 zero.
REQ-024 A single SubWord datapath (4 S-boxes) SHALL be shared by FWD and OUT, with its input muxed between w3 (FWD) and p3 (OUT).
REQ-025 The block SHALL use no combinational path from rk_ready to rk_valid.

Reset
REQ-026 While rst_n=0, regardless of state, the block SHALL force:
- FSM = IDLE
- rc = 0
- working register = 0
- rk_valid = 0, rk = 0, rk_idx = 0, busy = 0, done = 0
REQ-027 Reset asserted mid-FWD or mid-OUT SHALL abort the schedule; no further rk_valid SHALL occur until a new start.

Structure
REQ-028 Package aes_pkg SHALL hold:
- the FSM state enum
- the NR and NK=4 constants
- the RCON table
- the 128-bit round key typedef
REQ-029 The block SHALL have one sub-module, aes_sbox (8-bit combinational FIPS-197 S-box), instantiated 4 times.

Verification
REQ-030 The bench SHALL check: key=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 -> cycle T+11 gives rk=d014f9a8c9ee2589e13f0cc8b6630ca6 and idx=10; idx=1 gives a0fafe1788542cb123a339392a6c7605; idx=0 gives the key; done at T+22.
REQ-031 The bench SHALL check: key=0, start -> first rk=b4ef5bcb3e92e21123e951cf6f8f188e (idx 10), last rk=0 (idx 0).
REQ-032 The bench SHALL check: rk_ready low for 5 cycles at idx=7 -> rk/idx/valid stable, then the sequence resumes with idx=6 and no skip or repeat.
REQ-033 The bench SHALL check: start pulsed at idx=4 with a different key -> ignored; the remaining keys match the original key's schedule.
REQ-034 The bench SHALL check: rst_n low at idx=5 -> all outputs 0 immediately; a subsequent start yields the correct full sequence.
REQ-035 The bench SHALL check: start held high continuously -> back-to-back schedules, each with 11 handshakes and one done pulse.
